// File: rtl/enoc_pkg.sv
// Shared ENoC definitions: router port indices, port-count constants and the
// one-hot output-port request type.
package enoc_pkg;

  // Router port indices (0 = local/eject, then the mesh/torus directions).
  localparam int PORT_L  = 0;
  localparam int PORT_YP = 1;
  localparam int PORT_XP = 2;
  localparam int PORT_YM = 3;
  localparam int PORT_XM = 4;
  localparam int PORT_ZM = 5;
  localparam int PORT_ZP = 6;

  // Port counts for 2D (5-port) and 3D (7-port) routers.
  localparam int NUM_PORTS_2D = 5;
  localparam int NUM_PORTS_3D = 7;

  // One-hot output-port request; bit 0 (leftmost) is the local port.
  typedef logic [0:NUM_PORTS_3D-1] port_onehot_t;

endpackage

// File: rtl/enoc_rr_arbiter.sv
// N-way round-robin arbiter for one router output port.
// The grant is combinational; the priority pointer moves past the winner
// only when the advance strobe is high on a granted cycle.
module enoc_rr_arbiter
  import enoc_pkg::*;
#(
  parameter int N = NUM_PORTS_3D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:N-1] req,
  input  logic         en,
  input  logic         adv,
  output logic [0:N-1] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] prio_q;
  logic [IW-1:0] winner;
  logic          found;
  int            idx;

  // Pick the first requester at or after prio_q, wrapping modulo N.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(prio_q) + i) % N;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = IW'(idx);
        found      = 1'b1;
      end
    end
  end

  // Advance the pointer to just past the winner when a packet completes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so all flops update from pre-edge values.
    if (reset) begin
      prio_q <= '0;
    end else if (adv && found) begin
      prio_q <= (int'(winner) == N - 1) ? '0 : winner + IW'(1);
    end
  end

endmodule

// File: rtl/enoc_switch_allocator.sv
// ENoC switch allocator: arbitrates each output port among the input ports,
// returning a crossbar select per output and a pop strobe per input.
// Optional macro ENOC_WORMHOLE_LOCK_EN: when defined, a granted non-tail flit
// locks the output to its input until that input's tail flit is granted;
// when undefined, every flit is arbitrated independently and i_tail is unused.
module enoc_switch_allocator
  import enoc_pkg::*;
#(
  parameter int N = NUM_PORTS_3D,
  parameter int M = NUM_PORTS_3D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:N-1][0:M-1]  i_output_req,
  input  logic [0:N-1]         i_tail,
  input  logic [0:M-1]         i_en,
  output logic [0:M-1][0:N-1]  o_output_grant,
  output logic [0:N-1]         o_input_grant,
  output logic [0:M-1]         o_output_val
);

  logic [0:M-1][0:N-1] req_by_out;
  logic [0:M-1][0:N-1] elig_req;
  logic [0:M-1][0:N-1] grant;
  logic [0:M-1]        adv;

  // Column view: for each output, which inputs are requesting it.
  always_comb begin
    req_by_out = '0;
    for (int m = 0; m < M; m++) begin
      for (int k = 0; k < N; k++) begin
        req_by_out[m][k] = i_output_req[k][m];
      end
    end
  end

`ifdef ENOC_WORMHOLE_LOCK_EN
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [0:M-1]  lock_q;
  logic [IW-1:0] owner_q [M];
  logic [IW-1:0] winner  [M];

  // While locked, only the owning input may compete for the output.
  always_comb begin
    elig_req = req_by_out;
    for (int m = 0; m < M; m++) begin
      if (lock_q[m]) begin
        elig_req[m]              = '0;
        elig_req[m][owner_q[m]]  = req_by_out[m][owner_q[m]];
      end
    end
  end

  // Identify each output's winner and whether its flit ends the packet.
  always_comb begin
    adv = '0;
    for (int m = 0; m < M; m++) begin
      winner[m] = '0;
      for (int k = 0; k < N; k++) begin
        if (grant[m][k]) begin
          winner[m] = IW'(k);
          adv[m]    = i_tail[k];
        end
      end
    end
  end

  // Lock on a granted body flit, release on the owner's granted tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= '0;
      // NOTE: owner_q is a handful of flops, not a RAM, so it is reset with the lock.
      for (int m = 0; m < M; m++) owner_q[m] <= '0;
    end else begin
      for (int m = 0; m < M; m++) begin
        if (|grant[m]) begin
          if (adv[m]) begin
            lock_q[m] <= 1'b0;
          end else begin
            lock_q[m]  <= 1'b1;
            owner_q[m] <= winner[m];
          end
        end
      end
    end
  end
`else
  logic tail_unused;

  // Single-flit packets: every grant is a tail and moves the pointer.
  assign elig_req    = req_by_out;
  assign adv         = '1;
  assign tail_unused = ^i_tail;
`endif

  // One round-robin arbiter per output; grants are suppressed during reset.
  for (genvar m = 0; m < M; m++) begin : g_arb
    enoc_rr_arbiter #(.N(N)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (elig_req[m]),
      .en    (i_en[m] & ~reset),
      .adv   (adv[m]),
      .grant (grant[m])
    );
  end

  // Fan grants out to the crossbar selects, input pops and output valids.
  always_comb begin
    o_output_grant = grant;
    o_input_grant  = '0;
    o_output_val   = '0;
    for (int m = 0; m < M; m++) begin
      o_output_val[m] = |grant[m];
      o_input_grant   = o_input_grant | grant[m];
    end
  end

  // Each input may request at most one output per cycle.
  for (genvar k = 0; k < N; k++) begin : g_chk
    a_req_onehot: assert property (@(posedge clk) disable iff (reset)
                                   $onehot0(i_output_req[k]));
  end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Self-checking bench for enoc_switch_allocator: directed scenarios plus
// randomized traffic, all compared against a packet-level reference model.
module tb_enoc_switch_allocator;
  import enoc_pkg::*;

  localparam int N = NUM_PORTS_3D;
  localparam int M = NUM_PORTS_3D;
`ifdef ENOC_WORMHOLE_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [0:N-1][0:M-1] i_output_req;
  logic [0:N-1]        i_tail;
  logic [0:M-1]        i_en;
  logic [0:M-1][0:N-1] o_output_grant;
  logic [0:N-1]        o_input_grant;
  logic [0:M-1]        o_output_val;

  enoc_switch_allocator #(.N(N), .M(M)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_output_req   (i_output_req),
    .i_tail         (i_tail),
    .i_en           (i_en),
    .o_output_grant (o_output_grant),
    .o_input_grant  (o_input_grant),
    .o_output_val   (o_output_val)
  );

  always #5 clk = ~clk;

  // Stimulus as a destination per input (-1 = idle).
  int         dest [N];
  bit         tail_v [N];
  bit [0:M-1] en_v;
  bit         rst_v;

  // Reference model state and expected outputs.
  int  m_prio  [M];
  int  m_owner [M];
  bit  m_lock  [M];
  int  win     [M];
  logic [0:M-1][0:N-1] exp_og;
  logic [0:N-1]        exp_ig;
  logic [0:M-1]        exp_ov;

  int total = 0;
  int bad   = 0;

  function automatic logic [0:N-1] oh(input int k);
    oh = '0;
    if (k >= 0) oh[k] = 1'b1;
  endfunction

  // Who wins each output this cycle, from the allocation rules.
  task automatic model_eval();
    exp_og = '0;
    exp_ig = '0;
    exp_ov = '0;
    for (int m = 0; m < M; m++) begin
      win[m] = -1;
      if (!rst_v && en_v[m]) begin
        if (LOCK_EN && m_lock[m]) begin
          if (dest[m_owner[m]] == m) win[m] = m_owner[m];
        end else begin
          for (int d = 0; d < N; d++) begin
            if (win[m] < 0 && dest[(m_prio[m] + d) % N] == m) win[m] = (m_prio[m] + d) % N;
          end
        end
      end
      if (win[m] >= 0) begin
        exp_og[m][win[m]] = 1'b1;
        exp_ig[win[m]]    = 1'b1;
        exp_ov[m]         = 1'b1;
      end
    end
  endtask

  // Model state advances at the same edge as the DUT.
  always @(posedge clk) begin
    for (int m = 0; m < M; m++) begin
      if (rst_v) begin
        m_prio[m] = 0; m_lock[m] = 0; m_owner[m] = 0;
      end else if (win[m] >= 0) begin
        if (!LOCK_EN || tail_v[win[m]]) begin
          m_prio[m] = (win[m] + 1) % N;
          m_lock[m] = 0;
        end else begin
          m_lock[m]  = 1;
          m_owner[m] = win[m];
        end
      end
    end
  end

  // Drive one cycle of stimulus after the falling edge, then settle.
  task automatic step();
    @(negedge clk);
    reset  = rst_v;
    i_en   = en_v;
    for (int k = 0; k < N; k++) begin
      i_output_req[k] = '0;
      if (dest[k] >= 0) i_output_req[k][dest[k]] = 1'b1;
      i_tail[k] = tail_v[k];
    end
    #2;
    model_eval();
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < N; k++) begin
      dest[k] = -1; tail_v[k] = 1'b0;
    end
    en_v  = '1;
    rst_v = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_v = 1'b1; dest[1] = 2; tail_v[1] = 1'b1; dest[4] = 0;
    step();
    total++;
    if ({o_output_grant, o_input_grant, o_output_val} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: og=%h ig=%b ov=%b want all zero", o_output_grant, o_input_grant, o_output_val);
    end
    clear_inputs();
  endtask

  task automatic test_rr_alternate();
    int seq [3] = '{1, 3, 1};
    clear_inputs();
    dest[1] = 2; dest[3] = 2; tail_v[1] = 1'b1; tail_v[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (o_input_grant !== oh(seq[c]) || o_output_grant[2] !== oh(seq[c])) begin
        bad++;
        $display("FAIL rr_alternate c%0d: ig=%b og2=%b want %b", c, o_input_grant, o_output_grant[2], oh(seq[c]));
      end
    end
  endtask

  task automatic test_wormhole();
`ifdef ENOC_WORMHOLE_LOCK_EN
    int seq [4] = '{4, 4, 4, 2};
`else
    int seq [4] = '{4, 2, 4, 2};
`endif
    clear_inputs();
    dest[2] = 0; tail_v[2] = 1'b1;
    step();  // single flit from input 2 leaves output 0 pointing at input 3
    total++;
    if (o_output_grant[0] !== oh(2)) begin
      bad++;
      $display("FAIL wormhole_setup: og0=%b want %b", o_output_grant[0], oh(2));
    end
    for (int c = 0; c < 4; c++) begin
      dest[4] = (c < 3) ? 0 : -1;
      tail_v[4] = (c == 2);
      step();
      total++;
      if (o_output_grant[0] !== oh(seq[c]) || o_output_grant !== exp_og) begin
        bad++;
        $display("FAIL wormhole c%0d: og0=%b want %b", c, o_output_grant[0], oh(seq[c]));
      end
    end
  endtask

  task automatic test_bubble();
`ifdef ENOC_WORMHOLE_LOCK_EN
    int seq [5] = '{4, -1, -1, 4, 2};
`else
    int seq [5] = '{4, 2, 2, 4, 2};
`endif
    clear_inputs();
    dest[2] = 0; tail_v[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      dest[4]   = (c == 0 || c == 3) ? 0 : -1;
      tail_v[4] = (c == 3);
      step();
      total++;
      if (o_output_grant[0] !== oh(seq[c]) || o_output_val[0] !== (seq[c] >= 0)) begin
        bad++;
        $display("FAIL bubble c%0d: og0=%b ov0=%b want %b", c, o_output_grant[0], o_output_val[0], oh(seq[c]));
      end
    end
  endtask

  task automatic test_enable();
    clear_inputs();
    dest[0] = 5; tail_v[0] = 1'b1;
    en_v[5] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) en_v[5] = 1'b1;
      step();
      total++;
      if (o_output_grant[5] !== oh((c == 4) ? 0 : -1) || o_input_grant[0] !== (c == 4)) begin
        bad++;
        $display("FAIL enable c%0d: og5=%b ig=%b want %b", c, o_output_grant[5], o_input_grant, oh((c == 4) ? 0 : -1));
      end
    end
  endtask

  task automatic test_wrap();
    int seq [3] = '{5, 6, 0};
    clear_inputs();
    dest[5] = 1; tail_v[5] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        dest[5] = -1;
        dest[6] = 1; tail_v[6] = 1'b1;
        dest[0] = 1; tail_v[0] = 1'b1;
      end
      step();
      total++;
      if (o_output_grant[1] !== oh(seq[c])) begin
        bad++;
        $display("FAIL wrap c%0d: og1=%b want %b", c, o_output_grant[1], oh(seq[c]));
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_inputs();
    dest[4] = 0; tail_v[4] = 1'b0;
    dest[2] = 0; tail_v[2] = 1'b1;
    step();
    total++;
    if (o_output_grant[0] !== oh(4)) begin
      bad++;
      $display("FAIL midpkt_head: og0=%b want %b", o_output_grant[0], oh(4));
    end
    rst_v = 1'b1;
    step();
    total++;
    if ({o_output_grant, o_input_grant, o_output_val} !== '0) begin
      bad++;
      $display("FAIL midpkt_reset: og=%h ig=%b ov=%b want all zero", o_output_grant, o_input_grant, o_output_val);
    end
    rst_v = 1'b0;
    step();
    total++;
    if (o_output_grant[0] !== oh(2) || o_input_grant !== oh(2)) begin
      bad++;
      $display("FAIL midpkt_after: og0=%b ig=%b want %b", o_output_grant[0], o_input_grant, oh(2));
    end
  endtask

  task automatic test_random();
    clear_inputs();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        dest[k]   = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, M - 1));
        tail_v[k] = ($urandom_range(0, 1) == 1);
      end
      for (int m = 0; m < M; m++) en_v[m] = ($urandom_range(0, 4) != 0);
      rst_v = ($urandom_range(0, 49) == 0);
      step();
      total++;
      if ({o_output_grant, o_input_grant, o_output_val} !== {exp_og, exp_ig, exp_ov}) begin
        bad++;
        $display("FAIL random c%0d: og=%h ig=%b ov=%b want og=%h ig=%b ov=%b",
                 c, o_output_grant, o_input_grant, o_output_val, exp_og, exp_ig, exp_ov);
      end
    end
  endtask

  initial begin
    for (int m = 0; m < M; m++) win[m] = -1;
    clear_inputs();
    rst_v        = 1'b1;
    reset        = 1'b1;
    i_output_req = '0;
    i_tail       = '0;
    i_en         = '1;
    step();
    step();
    test_reset();
    test_rr_alternate();
    test_wormhole();
    test_bubble();
    test_enable();
    test_wrap();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
